// File: rtl/adc_buffer.sv
// Serial ADC front-end: frames one FRAME_BITS-bit conversion per SAMPLE_PERIOD
// cycles on an active-low chip select and publishes the captured word in parallel.
module adc_buffer #(
    parameter int SAMPLE_PERIOD = 250000,
    parameter int FRAME_BITS    = 16,
    localparam int CW           = $clog2(SAMPLE_PERIOD)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  adcData,
    output logic [FRAME_BITS-1:0] dataOut,
    output logic                  CSOut
);

    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_PERIOD - 1);
    localparam logic [CW-1:0] CS_FALL  = CW'(1);
    // CS is still low on this edge, so it is also the last sampling edge.
    localparam logic [CW-1:0] CS_RISE  = CW'(FRAME_BITS + 1);

    logic [CW-1:0]         cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] shreg_nxt;

    assign shreg_nxt = {adcData, shreg[FRAME_BITS-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            CSOut   <= 1'b1;
            shreg   <= '0;
            dataOut <= '0;
        end else begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

            if (cnt == CS_FALL)
                CSOut <= 1'b0;
            else if (cnt == CS_RISE)
                CSOut <= 1'b1;

            if (!CSOut) begin
                shreg <= shreg_nxt;
                if (cnt == CS_RISE)
                    dataOut <= shreg_nxt;
            end
        end
    end

endmodule

// File: tb/tb_adc_buffer.sv
// Randomized bench for adc_buffer: edge-indexed reference model of CS timing
// and captured frames, plus directed frames and a mid-frame reset.
module tb_adc_buffer;

    localparam int P  = 40;
    localparam int FB = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          adcData = 1'b0;
    logic [FB-1:0] dataOut;
    logic          CSOut;

    int            n_chk = 0;
    int            n_fail = 0;
    int            e = 0;
    int            low_cnt = 0;
    logic [FB-1:0] bits = '0;
    logic [FB-1:0] exp_data = '0;
    logic [11:0]   payload = '0;

    adc_buffer #(.SAMPLE_PERIOD(P), .FRAME_BITS(FB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .adcData (adcData),
        .dataOut (dataOut),
        .CSOut   (CSOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, expv, e);
        end
    endtask

    // Bit to present before the edge with frame phase ph: 4 zeros, 12 payload
    // bits, and random noise whenever CS should be high.
    function automatic logic gen_bit(input int ph);
        if (ph >= 2 && ph <= 5) return 1'b0;
        if (ph >= 6 && ph <= FB + 1) return payload[ph - 6];
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic tick();
        int ph;
        @(posedge clk);
        ph = e % P;
        if (ph >= 2 && ph <= FB + 1) bits[ph - 2] = adcData;
        if (ph == FB + 1) exp_data = bits;
        e++;
        #1;
        chk("cs", 16'(CSOut), (ph >= 1 && ph <= FB) ? 16'd0 : 16'd1);
        chk("data", dataOut, exp_data);
        if (!CSOut) low_cnt++;
        adcData = gen_bit(e % P);
    endtask

    task automatic run_frame(input logic [11:0] pl, input string tag);
        payload = pl;
        adcData = gen_bit(e % P);
        low_cnt = 0;
        repeat (FB + 2) tick();
        chk(tag, dataOut, {pl, 4'b0000});
        repeat (P - FB - 2) tick();
        chk("cs_low_cycles", 16'(low_cnt), 16'd16);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        e = 0;
        exp_data = '0;
        bits = '0;
        adcData = gen_bit(0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", 16'(CSOut), 16'd1);
        chk("rst_data", dataOut, 16'h0000);
        release_reset();

        // Directed frame: 4 zeros then 1,0,1,1,0,0,1,0,1,1,1,0.
        run_frame(12'h74D, "frame_directed");
        chk("directed_const", dataOut, 16'h74D0);

        for (int f = 0; f < 8; f++) run_frame(12'($urandom), "frame_rand");

        run_frame(12'hFFF, "frame_ones");
        chk("ones_const", dataOut, 16'hFFF0);

        // Reset asserted just after edge 10 of a frame.
        payload = 12'($urandom);
        adcData = gen_bit(e % P);
        repeat (11) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_cs", 16'(CSOut), 16'd1);
        chk("midrst_data", dataOut, 16'h0000);
        @(posedge clk);
        #1;
        chk("midrst_hold_data", dataOut, 16'h0000);
        release_reset();

        run_frame(12'h5A3, "frame_after_rst");
        run_frame(12'($urandom), "frame_rand_tail");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
